jalfor_loop_ctrl: RTL and testbench
===================================

# jalfor_loop_ctrl

Hardware loop sequencer for the single-cycle core's `jalfor` instruction. On a decoded `jalfor` it redirects the PC to the loop body, counts retired body instructions, re-enters the body for each outer iteration and finally returns to the instruction after `jalfor`. It sits between the control decoder and the PC-select mux, replacing ad-hoc loop registers with a reset-safe, stall-aware controller.

## Interface
- `AW`, 32, PC / address width
- `CW`, 4, width of the iteration count (`nr`) and the body-length count (`necl`)

- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  `jalfor` decoded in the current instruction (level, one cycle per instruction)
- `stall`  in  1  PC does not load this cycle; the controller freezes
- `abort`  in  1  flush request; cancels any active loop
- `tgt_addr`  in  AW  loop body start address (zero-extended `instruc[15:0]`)
- `ret_addr`  in  AW  return address (PC+4 of the `jalfor`)
- `nr`  in  CW  outer iteration count (`instruc[23:20]`)
- `necl`  in  CW  instructions per body (`instruc[19:16]`)
- `pc_seq`  in  AW  datapath's normal next PC (branch/jump mux output)
- `pc_next`  out  AW  PC to load
- `redirect`  out  1  `pc_next` differs from `pc_seq` source this cycle
- `busy`  out  1  loop active (state RUN)
- `iter_left`  out  CW  outer iterations remaining, including the current one
- `inst_left`  out  CW  body instructions remaining in the current iteration, including the current one
- `done`  out  1  one-cycle pulse after the final return redirect
- `err`  out  1  one-cycle pulse after a rejected `start`

## Operation
- States: IDLE, RUN. Reset -> IDLE; `busy`=0, `iter_left`=0, `inst_left`=0, `done`=0, `err`=0.
- `redirect`/`pc_next` are combinational (Mealy). Default: `redirect`=0, `pc_next`=`pc_seq`.
- Any cycle with `stall`=1: defaults apply, no state/counter change, and `start`/`abort` are ignored.
- IDLE, `start`=1, `nr`!=0, `necl`!=0: `redirect`=1, `pc_next`=`tgt_addr`; latch `tgt_addr`, `ret_addr`, `necl`; `iter_left`<=`nr`; `inst_left`<=`necl`; -> RUN.
- IDLE, `start`=1 with `nr`=0 or `necl`=0: no redirect (the instruction behaves as a nop); `err` pulses next cycle; stay IDLE.
- RUN, each unstalled cycle retires one body instruction:
  - `inst_left`>1: defaults; `inst_left`<=`inst_left`-1.
  - `inst_left`=1 and `iter_left`>1: `redirect`=1, `pc_next`=latched target; `iter_left`<=`iter_left`-1; `inst_left`<=latched `necl`.
  - `inst_left`=1 and `iter_left`=1: `redirect`=1, `pc_next`=latched return address; counters<=0; -> IDLE; `done` pulses next cycle.
- RUN, `start`=1 (a nested `jalfor`): ignored, with no redirect. `err` pulses and the count proceeds as for a normal body instruction.
- `abort`=1 (unstalled): highest priority; defaults; -> IDLE; counters<=0; no `done`. In IDLE, `abort` also suppresses `start`.
- Counters are unsigned CW-bit values and never wrap: the zero cases are rejected and decrements occur only from values ≥1.
- Body branches and jumps inside the loop are not tracked. `pc_seq` passes through and only retired-instruction counts matter.

## Timing
- Zero-cycle redirect latency: the `start` cycle itself drives `pc_next`=`tgt_addr`.
- State, counters and latched addresses update on the rising `clk` edge. `done`/`err` are registered, appearing for the cycle after the event.
- Total cycles from the `start` cycle to the return redirect, inclusive, is `nr`×`necl`+1, unstalled.
- `rst_n` low at any time forces IDLE immediately (asynchronous), including mid-loop. The first edge after release samples normally.
- `busy` goes high the cycle after an accepted `start` and goes low the cycle after the final redirect (the same cycle as `done`).

## Test plan
- Basic: `nr`=2, `necl`=3, `tgt_addr`=0x40, `ret_addr`=0x0C, `pc_seq`=PC+4 -> redirects at C0 (0x40), C3 (0x40) and C6 (0x0C); `pc_next` is 0x44/0x48 at C1/C2 and at C4/C5; `done`=1 at C7 only; `busy` is high C1–C6.
- Single: `nr`=1, `necl`=1 -> C0 redirect to `tgt_addr`, C1 redirect to `ret_addr`, `done` at C2.
- Rejects: `start` with `nr`=0 -> `redirect`=0, `err`=1 next cycle, `busy` stays 0. Nested `start` at C2 of the basic case -> `err` at C3, and the redirect schedule is unchanged.
- Stall: basic case with `stall`=1 during C2–C3 -> the schedule shifts by 2 cycles; `redirect`=0 and counters hold while stalled; `start` asserted under stall is not accepted.
- Abort/reset: `abort` at C4 of the basic case -> no redirect at C4, IDLE at C5, no `done`. `rst_n` pulled low mid-loop -> outputs reach reset values at once, and a later `start` runs cleanly from `nr`, `necl`.

Source files
------------

// File: rtl/jalfor_loop_ctrl.sv
// Hardware loop sequencer for the jalfor instruction: redirects the PC into the
// loop body, counts retired body instructions per iteration and returns after the last.
module jalfor_loop_ctrl #(
  parameter int AW = 32,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic          abort,
  input  logic [AW-1:0] tgt_addr,
  input  logic [AW-1:0] ret_addr,
  input  logic [CW-1:0] nr,
  input  logic [CW-1:0] necl,
  input  logic [AW-1:0] pc_seq,
  output logic [AW-1:0] pc_next,
  output logic          redirect,
  output logic          busy,
  output logic [CW-1:0] iter_left,
  output logic [CW-1:0] inst_left,
  output logic          done,
  output logic          err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic [CW-1:0] inst_q, inst_d;
  logic [CW-1:0] necl_q, necl_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic [AW-1:0] ret_q, ret_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // NOTE: every signal driven here gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    inst_d   = inst_q;
    necl_d   = necl_q;
    tgt_d    = tgt_q;
    ret_d    = ret_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    redirect = 1'b0;
    pc_next  = pc_seq;

    if (!stall) begin
      if (abort) begin
        state_d = IDLE;
        iter_d  = '0;
        inst_d  = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              if (nr != '0 && necl != '0) begin
                redirect = 1'b1;
                pc_next  = tgt_addr;
                tgt_d    = tgt_addr;
                ret_d    = ret_addr;
                necl_d   = necl;
                iter_d   = nr;
                inst_d   = necl;
                state_d  = RUN;
              end else begin
                err_d = 1'b1;
              end
            end
          end
          RUN: begin
            // A nested jalfor retires as an ordinary body instruction.
            err_d = start;
            if (inst_q > ONE) begin
              inst_d = inst_q - ONE;
            end else if (iter_q > ONE) begin
              redirect = 1'b1;
              pc_next  = tgt_q;
              iter_d   = iter_q - ONE;
              inst_d   = necl_q;
            end else begin
              redirect = 1'b1;
              pc_next  = ret_q;
              iter_d   = '0;
              inst_d   = '0;
              done_d   = 1'b1;
              state_d  = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      inst_q  <= '0;
      necl_q  <= '0;
      tgt_q   <= '0;
      ret_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      inst_q  <= inst_d;
      necl_q  <= necl_d;
      tgt_q   <= tgt_d;
      ret_q   <= ret_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign iter_left = iter_q;
  assign inst_left = inst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jalfor_loop_ctrl.sv
// Self-checking bench for jalfor_loop_ctrl: per-cycle vector tables fed through
// an expectation queue, plus hand-written reset and long-loop sequences.
module tb_jalfor_loop_ctrl;

  localparam int AW = 32;
  localparam int CW = 4;
  localparam logic [AW-1:0] TGT = 32'h40;
  localparam logic [AW-1:0] RET = 32'h0C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stall, abort;
  logic [AW-1:0] tgt_addr, ret_addr, pc_seq, pc_next;
  logic [CW-1:0] nr, necl, iter_left, inst_left;
  logic          redirect, busy, done, err;

  jalfor_loop_ctrl #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
    .tgt_addr(tgt_addr), .ret_addr(ret_addr), .nr(nr), .necl(necl),
    .pc_seq(pc_seq), .pc_next(pc_next), .redirect(redirect), .busy(busy),
    .iter_left(iter_left), .inst_left(inst_left), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // One record per cycle: inputs for the cycle, expected Mealy outputs in that
  // cycle, and expected registered outputs visible during that cycle.
  typedef struct {
    logic          start, stall, abort;
    logic [CW-1:0] nr, necl;
    logic [AW-1:0] pc_seq;
    logic          redir;
    logic [AW-1:0] pcn;
    logic          busy;
    logic [CW-1:0] iter, inst;
    logic          done, err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(bit st, bit sl, bit ab, int r, int e, int pcs,
                              bit rd, int pcn, bit bz, int it, int in, bit dn, bit er);
    vec_t v;
    v.start = st; v.stall = sl; v.abort = ab;
    v.nr = CW'(r); v.necl = CW'(e); v.pc_seq = AW'(pcs);
    v.redir = rd; v.pcn = AW'(pcn); v.busy = bz;
    v.iter = CW'(it); v.inst = CW'(in); v.done = dn; v.err = er;
    vecs.push_back(v);
  endfunction

  task automatic idle_inputs();
    start = 1'b0; stall = 1'b0; abort = 1'b0; nr = '0; necl = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive each vector at the falling edge, queue its expectation, and compare
  // against the DUT 2 ns later, well clear of the rising edge.
  task automatic run_table(input string tag);
    vec_t exp;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start = vecs[i].start; stall = vecs[i].stall; abort = vecs[i].abort;
      nr = vecs[i].nr; necl = vecs[i].necl; pc_seq = vecs[i].pc_seq;
      sb_q.push_back(vecs[i]);
      #2;
      exp = sb_q.pop_front();
      check($sformatf("%s[%0d] redirect", tag, i), AW'(redirect), AW'(exp.redir));
      check($sformatf("%s[%0d] pc_next", tag, i), pc_next, exp.pcn);
      check($sformatf("%s[%0d] busy", tag, i), AW'(busy), AW'(exp.busy));
      check($sformatf("%s[%0d] iter_left", tag, i), AW'(iter_left), AW'(exp.iter));
      check($sformatf("%s[%0d] inst_left", tag, i), AW'(inst_left), AW'(exp.inst));
      check($sformatf("%s[%0d] done", tag, i), AW'(done), AW'(exp.done));
      check($sformatf("%s[%0d] err", tag, i), AW'(err), AW'(exp.err));
    end
    vecs.delete();
    @(negedge clk);
    idle_inputs();
  endtask

  // nr=2, necl=3 loop; optional nested start in C2.
  function automatic void basic_table(bit nested);
    //   st sl ab nr ne  pcs   rd pcn   bz it in dn er
    add(1, 0, 0, 2, 3, 'h0C, 1, 'h40, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'h44, 0, 'h44, 1, 2, 3, 0, 0);
    add(nested, 0, 0, 5, 5, 'h48, 0, 'h48, 1, 2, 2, 0, 0);
    add(0, 0, 0, 0, 0, 'h4C, 1, 'h40, 1, 2, 1, 0, nested);
    add(0, 0, 0, 0, 0, 'h44, 0, 'h44, 1, 1, 3, 0, 0);
    add(0, 0, 0, 0, 0, 'h48, 0, 'h48, 1, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 'h4C, 1, 'h0C, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 'h10, 0, 'h10, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 'h14, 0, 'h14, 0, 0, 0, 0, 0);
  endfunction

  int  n_cyc, n_redir;
  bit  found;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tgt_addr = TGT;
    ret_addr = RET;
    pc_seq   = 32'h0C;

    // Reset state
    #3;
    check("reset busy", AW'(busy), 0);
    check("reset iter_left", AW'(iter_left), 0);
    check("reset inst_left", AW'(inst_left), 0);
    check("reset done", AW'(done), 0);
    check("reset err", AW'(err), 0);
    check("reset redirect", AW'(redirect), 0);
    @(negedge clk);
    rst_n = 1'b1;

    basic_table(1'b0);
    run_table("basic");

    do_reset();
    basic_table(1'b1);
    run_table("nested");

    do_reset();
    add(1, 0, 0, 1, 1, 'h0C, 1, 'h40, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'h44, 1, 'h0C, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 'h10, 0, 'h10, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 'h14, 0, 'h14, 0, 0, 0, 0, 0);
    run_table("single");

    // Rejected, stalled and aborted starts in IDLE
    do_reset();
    add(1, 0, 0, 0, 3, 'h0C, 0, 'h0C, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'h10, 0, 'h10, 0, 0, 0, 0, 1);
    add(1, 0, 0, 2, 0, 'h14, 0, 'h14, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'h18, 0, 'h18, 0, 0, 0, 0, 1);
    add(1, 1, 0, 2, 3, 'h1C, 0, 'h1C, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 3, 'h1C, 0, 'h1C, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'h20, 0, 'h20, 0, 0, 0, 0, 0);
    run_table("reject");

    // Stall during C2-C3, with a start asserted while stalled
    do_reset();
    add(1, 0, 0, 2, 3, 'h0C, 1, 'h40, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'h44, 0, 'h44, 1, 2, 3, 0, 0);
    add(1, 1, 0, 2, 3, 'h48, 0, 'h48, 1, 2, 2, 0, 0);
    add(0, 1, 1, 0, 0, 'h48, 0, 'h48, 1, 2, 2, 0, 0);
    add(0, 0, 0, 0, 0, 'h48, 0, 'h48, 1, 2, 2, 0, 0);
    add(0, 0, 0, 0, 0, 'h4C, 1, 'h40, 1, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 'h44, 0, 'h44, 1, 1, 3, 0, 0);
    add(0, 0, 0, 0, 0, 'h48, 0, 'h48, 1, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 'h4C, 1, 'h0C, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 'h10, 0, 'h10, 0, 0, 0, 1, 0);
    run_table("stall");

    // Abort at C4
    do_reset();
    add(1, 0, 0, 2, 3, 'h0C, 1, 'h40, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'h44, 0, 'h44, 1, 2, 3, 0, 0);
    add(0, 0, 0, 0, 0, 'h48, 0, 'h48, 1, 2, 2, 0, 0);
    add(0, 0, 0, 0, 0, 'h4C, 1, 'h40, 1, 2, 1, 0, 0);
    add(0, 0, 1, 0, 0, 'h44, 0, 'h44, 1, 1, 3, 0, 0);
    add(0, 0, 0, 0, 0, 'h48, 0, 'h48, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'h4C, 0, 'h4C, 0, 0, 0, 0, 0);
    run_table("abort");

    // Asynchronous reset mid-loop, then a clean rerun
    do_reset();
    add(1, 0, 0, 2, 3, 'h0C, 1, 'h40, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 'h44, 0, 'h44, 1, 2, 3, 0, 0);
    add(0, 0, 0, 0, 0, 'h48, 0, 'h48, 1, 2, 2, 0, 0);
    run_table("prerst");
    @(negedge clk);
    pc_seq = 32'h4C;
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", AW'(busy), 0);
    check("midrst iter_left", AW'(iter_left), 0);
    check("midrst inst_left", AW'(inst_left), 0);
    check("midrst redirect", AW'(redirect), 0);
    check("midrst pc_next", pc_next, 32'h4C);
    @(negedge clk);
    rst_n = 1'b1;
    basic_table(1'b0);
    run_table("postrst");

    // Widest counts: nr*necl+1 cycles to the return, nr redirects to target + 1 return
    do_reset();
    @(negedge clk);
    start = 1'b1; nr = 4'd15; necl = 4'd15; pc_seq = 32'h0C;
    n_cyc = 0; n_redir = 0; found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      #2;
      n_cyc++;
      if (redirect) begin
        n_redir++;
        if (pc_next == RET) found = 1'b1;
      end
      @(negedge clk);
      idle_inputs();
      pc_seq = 32'h100;
    end
    #2;
    check("max return reached", AW'(found), 1);
    check("max cycle count", AW'(n_cyc), 226);
    check("max redirect count", AW'(n_redir), 16);
    check("max done", AW'(done), 1);
    check("max busy", AW'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
